// File: rtl/shift_pipe.sv
// shift_pipe: pipelined log-stage barrel shifter for FP significand
// alignment / normalisation.
//
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   in_valid / in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_sign, in, nshift   sign (passed through), magnitude, shift amount
//   mode                  00 lsr, 01 asr, 10 lsl, 11 ror
//   out_valid / out_ready output handshake
//   out_sign, out         delayed sign, shifted magnitude
//   guard, sticky         right-shift rounding bits
//   ovf                   left shift dropped a 1
//
// Stage i applies the shift for nshift bit SHW-1-i (largest amount first).
// The whole pipe advances together, so a stalled output freezes every stage.

module shift_pipe_stage #(
  parameter int WIDTH = 24,
  parameter int K     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_do,
  input  logic [1:0]       i_mode,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_sign,
  input  logic             i_g,
  input  logic             i_s,
  input  logic             i_o,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_val,
  output logic             o_sign,
  output logic             o_g,
  output logic             o_s,
  output logic             o_o
);
  localparam int KR   = K % WIDTH;
  // Guard is bit K-1 of the sign-extended value; past WIDTH it is the fill.
  localparam bit G_IN = (K - 1 < WIDTH);
  localparam int GI   = G_IN ? K - 1 : 0;
  localparam bit S_FILL = (K - 1 > WIDTH);

  logic             w_fill, w_gout, w_sto, w_ovo;
  logic [WIDTH-1:0] w_sr, w_sl, w_rr;
  logic [WIDTH-1:0] w_val;
  logic             w_g, w_s, w_o;

  logic             r_vld, r_sign, r_g, r_s, r_o;
  logic [WIDTH-1:0] r_val;

  always_comb begin
    w_fill = (i_mode == 2'b01) & i_val[WIDTH-1];
    w_sr   = '0;
    w_sl   = '0;
    w_rr   = '0;
    w_sto  = 1'b0;
    w_ovo  = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      w_sr[b] = (b + K < WIDTH) ? i_val[(b + K < WIDTH) ? b + K : 0] : w_fill;
      w_sl[b] = (b >= K) ? i_val[(b >= K) ? b - K : 0] : 1'b0;
      w_rr[b] = i_val[(b + KR) % WIDTH];
      if (b < K - 1)      w_sto = w_sto | i_val[b];
      if (b + K >= WIDTH) w_ovo = w_ovo | i_val[b];
    end
    w_gout = G_IN ? i_val[GI] : w_fill;
    if (S_FILL) w_sto = w_sto | w_fill;

    w_val = i_val;
    w_g   = i_g;
    w_s   = i_s;
    w_o   = i_o;
    if (i_do) begin
      case (i_mode)
        2'b00, 2'b01: begin
          // Fold the previous guard into sticky so the chain of stages
          // matches one single-step shift by the total amount.
          w_val = w_sr;
          w_g   = w_gout;
          w_s   = i_s | i_g | w_sto;
        end
        2'b10: begin
          w_val = w_sl;
          w_o   = i_o | w_ovo;
        end
        default: w_val = w_rr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_val  <= '0;
      r_sign <= 1'b0;
      r_g    <= 1'b0;
      r_s    <= 1'b0;
      r_o    <= 1'b0;
    end else if (i_en) begin
      r_vld  <= i_vld;
      r_val  <= w_val;
      r_sign <= i_sign;
      r_g    <= w_g;
      r_s    <= w_s;
      r_o    <= w_o;
    end
  end

  assign o_vld  = r_vld;
  assign o_val  = r_val;
  assign o_sign = r_sign;
  assign o_g    = r_g;
  assign o_s    = r_s;
  assign o_o    = r_o;
endmodule

module shift_pipe #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   nshift,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out,
  output logic             guard,
  output logic             sticky,
  output logic             ovf
);
  logic                      w_adv;
  logic [SHW:0]              vld_pipe;
  logic [SHW:0][WIDTH-1:0]   w_val;
  logic [SHW:0]              w_sign, w_g, w_s, w_o;
  logic [SHW-1:0][SHW-1:0]   w_nsh;
  logic [SHW-1:0][1:0]       w_mode;
  logic [SHW-1:0]            w_do;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Entry point: flags start clear for every beat.
  assign vld_pipe[0] = in_valid;
  assign w_val[0]    = in;
  assign w_sign[0]   = in_sign;
  assign w_g[0]      = 1'b0;
  assign w_s[0]      = 1'b0;
  assign w_o[0]      = 1'b0;
  assign w_nsh[0]    = nshift;
  assign w_mode[0]   = mode;

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int BIT = SHW - 1 - i;

    assign w_do[i] = |(w_nsh[i] & SHW'(1 << BIT));

    shift_pipe_stage #(.WIDTH(WIDTH), .K(1 << BIT)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_adv),
      .i_do   (w_do[i]),
      .i_mode (w_mode[i]),
      .i_vld  (vld_pipe[i]),
      .i_val  (w_val[i]),
      .i_sign (w_sign[i]),
      .i_g    (w_g[i]),
      .i_s    (w_s[i]),
      .i_o    (w_o[i]),
      .o_vld  (vld_pipe[i+1]),
      .o_val  (w_val[i+1]),
      .o_sign (w_sign[i+1]),
      .o_g    (w_g[i+1]),
      .o_s    (w_s[i+1]),
      .o_o    (w_o[i+1])
    );

    // Control travels alongside the data; the last stage has no successor.
    if (i < SHW - 1) begin : g_ctl
      logic [SHW-1:0] r_nsh;
      logic [1:0]     r_mode;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_nsh  <= '0;
          r_mode <= '0;
        end else if (w_adv) begin
          r_nsh  <= w_nsh[i];
          r_mode <= w_mode[i];
        end
      end
      assign w_nsh[i+1]  = r_nsh;
      assign w_mode[i+1] = r_mode;
    end
  end

  assign out_valid = vld_pipe[SHW];
  assign out       = w_val[SHW];
  assign out_sign  = w_sign[SHW];
  assign guard     = w_g[SHW];
  assign sticky    = w_s[SHW];
  assign ovf       = w_o[SHW];
endmodule
